// File: rtl/wr_burst_packer_pkg.sv
// Shared constants and FSM encoding for the camera write-burst packer.
package wr_burst_packer_pkg;

  localparam int unsigned PK_DQ_WIDTH   = 32;
  localparam int unsigned PK_WORD_WIDTH = PK_DQ_WIDTH * 8;
  localparam int unsigned PK_PIX_WIDTH  = 16;
  localparam int unsigned PK_BURST_LEN  = 16;

  typedef enum logic [1:0] {
    PK_IDLE = 2'd0,
    PK_FILL = 2'd1,
    PK_PAD  = 2'd2
  } pk_state_t;

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through synchronous FIFO; head word is visible without a read.
module sync_fifo_fwft #(
  parameter int unsigned WIDTH = 256,
  parameter int unsigned DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             pop_ok;
  logic             push_ok;

  // Occupancy and flags derive from the wrap-bit pointers only.
  always_comb begin
    level    = wr_ptr - rd_ptr;
    empty    = (wr_ptr == rd_ptr);
    full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    pop_ok   = pop & ~empty;
    push_ok  = push & (~full | pop_ok);
    pop_data = empty ? '0 : mem[rd_ptr[AW-1:0]];
  end

  // Storage array, written only on an accepted push.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  // Read/write pointers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/wr_burst_packer.sv
// Packs camera pixels into DDR words, buffers them, and pads each frame to whole bursts.
module wr_burst_packer import wr_burst_packer_pkg::*; #(
  parameter int unsigned DQ_WIDTH     = PK_DQ_WIDTH,
  parameter int unsigned PIX_WIDTH    = PK_PIX_WIDTH,
  parameter int unsigned BURST_LEN    = PK_BURST_LEN,
  parameter int unsigned FIFO_DEPTH   = 64,
  parameter int unsigned FRAME_WIDTH  = 1280,
  parameter int unsigned FRAME_HEIGHT = 720
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          pix_valid,
  input  logic [PIX_WIDTH-1:0]          pix_data,
  input  logic                          pix_vsync,
  output logic                          buf_rready,
  output logic [DQ_WIDTH*8-1:0]         buf_data,
  output logic                          buf_vsync,
  input  logic                          buf_rd_en,
  output logic [$clog2(FIFO_DEPTH):0]   buf_level,
  output logic                          frame_done,
  output logic                          overflow
);

  localparam int unsigned WORD_W    = DQ_WIDTH * 8;
  localparam int unsigned PPW       = WORD_W / PIX_WIDTH;
  localparam int unsigned IDX_W     = $clog2(PPW);
  localparam int unsigned TOTAL_PIX = FRAME_WIDTH * FRAME_HEIGHT;
  localparam int unsigned PCNT_W    = $clog2(TOTAL_PIX + 1);
  localparam int unsigned BCNT_W    = $clog2(BURST_LEN);
  localparam int unsigned LVL_W     = $clog2(FIFO_DEPTH) + 1;

  pk_state_t          state;
  logic               vs_d;
  logic               vs_d2;
  logic [WORD_W-1:0]  pack;
  logic [WORD_W-1:0]  word_r;
  logic               word_push_r;
  logic [IDX_W-1:0]   pix_idx;
  logic [PCNT_W-1:0]  pix_cnt;
  logic [BCNT_W-1:0]  burst_cnt;
  logic               frame_done_r;
  logic               overflow_r;

  logic               frame_start;
  logic               vs_rise;
  logic               accept_pix;
  logic               last_pix;
  logic               word_done;
  logic               exit_fill;
  logic               go_pad;
  logic [IDX_W-1:0]   idx_after;
  logic [BCNT_W-1:0]  bc_eff;
  logic [WORD_W-1:0]  pack_ins;
  logic               pad_push;

  logic               fifo_push;
  logic [WORD_W-1:0]  fifo_data;
  logic               fifo_full;
  logic               fifo_empty;
  logic [LVL_W-1:0]   fifo_level;
  logic               pop_eff;
  logic               fifo_accept;

  // Edge detection, packer insert, and push arbitration.
  always_comb begin
    frame_start = vs_d2 & ~vs_d;
    vs_rise     = vs_d & ~vs_d2;
    accept_pix  = (state == PK_FILL) && pix_valid;
    last_pix    = accept_pix && ((pix_cnt + 1'b1) == PCNT_W'(TOTAL_PIX));
    word_done   = accept_pix && (pix_idx == IDX_W'(PPW - 1));
    idx_after   = accept_pix ? pix_idx + 1'b1 : pix_idx;

    pack_ins = pack;
    pack_ins[int'(pix_idx) * PIX_WIDTH +: PIX_WIDTH] = pix_data;

    // The pad word may only follow a pending packed word, never overlap it.
    pad_push    = (state == PK_PAD) && !word_push_r && !fifo_full &&
                  ((pix_idx != '0) || (burst_cnt != '0));
    fifo_push   = word_push_r | pad_push;
    fifo_data   = word_push_r ? word_r : pack;
    pop_eff     = buf_rd_en & ~fifo_empty;
    fifo_accept = fifo_push & (~fifo_full | pop_eff);

    // Burst position once the in-flight push and this pixel's word are counted.
    bc_eff    = burst_cnt + BCNT_W'(fifo_accept) + BCNT_W'(word_done);
    exit_fill = (state == PK_FILL) && (last_pix || vs_rise);
    go_pad    = (idx_after != '0) || (bc_eff != '0);
  end

  // Frame FSM, packer, counters and sticky flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= PK_IDLE;
      vs_d         <= 1'b0;
      vs_d2        <= 1'b0;
      pack         <= '0;
      word_r       <= '0;
      word_push_r  <= 1'b0;
      pix_idx      <= '0;
      pix_cnt      <= '0;
      burst_cnt    <= '0;
      frame_done_r <= 1'b0;
      overflow_r   <= 1'b0;
    end else begin
      vs_d         <= pix_vsync;
      vs_d2        <= vs_d;
      frame_done_r <= last_pix;
      word_push_r  <= word_done;
      if (word_done)   word_r    <= pack_ins;
      if (fifo_accept) burst_cnt <= burst_cnt + 1'b1;

      if (frame_start)                     overflow_r <= 1'b0;
      else if (fifo_push && !fifo_accept)  overflow_r <= 1'b1;

      case (state)
        PK_IDLE: begin
          if (frame_start) begin
            state   <= PK_FILL;
            pix_cnt <= '0;
            pix_idx <= '0;
            pack    <= '0;
          end
        end
        PK_FILL: begin
          if (accept_pix) begin
            pix_cnt <= pix_cnt + 1'b1;
            pix_idx <= pix_idx + 1'b1;
            pack    <= word_done ? '0 : pack_ins;
          end
          if (exit_fill) state <= go_pad ? PK_PAD : PK_IDLE;
        end
        PK_PAD: begin
          if (pad_push) begin
            pack    <= '0;
            pix_idx <= '0;
          end
          if (!word_push_r && (pix_idx == '0) && (burst_cnt == '0)) state <= PK_IDLE;
        end
        default: state <= PK_IDLE;
      endcase
    end
  end

  sync_fifo_fwft #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (fifo_data),
    .pop       (buf_rd_en),
    .pop_data  (buf_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  // Output decode from registered state.
  always_comb begin
    buf_level  = fifo_level;
    buf_rready = (fifo_level >= LVL_W'(BURST_LEN));
    buf_vsync  = vs_d;
    frame_done = frame_done_r;
    overflow   = overflow_r;
  end

endmodule
